// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, coordinate types and decode helpers
// for the VGA scan driver and its scroll accumulator.
package vga_timing_pkg;

   localparam int H_DISPLAY = 640;
   localparam int H_FRONT   = 16;
   localparam int H_SYNC    = 96;
   localparam int H_BACK    = 48;
   localparam int H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;

   localparam int V_DISPLAY = 480;
   localparam int V_FRONT   = 10;
   localparam int V_SYNC    = 2;
   localparam int V_BACK    = 33;
   localparam int V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

   localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
   localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
   localparam int V_SYNC_START = V_DISPLAY + V_FRONT;
   localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

   localparam int SCROLL_WRAP_DEFAULT = 640;

   localparam int COORD_W = 10;
   localparam int SPEED_W = 3;
   localparam int FRAME_W = 8;

   typedef logic [COORD_W-1:0] coord_t;

   typedef struct packed {
      logic hsync;
      logic vsync;
      logic display_on;
      logic line_tick;
      logic frame_tick;
   } scan_flags_t;

   // Inactive levels: syncs are active low, everything else active high.
   localparam scan_flags_t FLAGS_IDLE = '{hsync: 1'b1, vsync: 1'b1, display_on: 1'b0,
                                          line_tick: 1'b0, frame_tick: 1'b0};

   function automatic logic in_window(input coord_t v, input coord_t lo, input coord_t hi);
      return (v >= lo) && (v <= hi);
   endfunction

endpackage

// File: rtl/scroll_accumulator.sv
// Per-frame modulo accumulator for the double-sine scroll offset:
// x_offset steps by speed whenever en is high and wraps at SCROLL_WRAP.
module scroll_accumulator #(
   parameter int SCROLL_WRAP = vga_timing_pkg::SCROLL_WRAP_DEFAULT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic [2:0] speed,
   output logic [9:0] x_offset
);
   import vga_timing_pkg::*;

   localparam logic [COORD_W:0] WRAP = (COORD_W + 1)'(SCROLL_WRAP);

   // One spare bit so offset + speed cannot overflow before the wrap compare.
   logic [COORD_W:0] sum;

   always_comb begin
      sum = {1'b0, x_offset} + {{(COORD_W + 1 - SPEED_W){1'b0}}, speed};
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values; blocking here would make results depend on block order.
   always_ff @(posedge clk) begin
      if (reset) begin
         x_offset <= '0;
      end else if (en) begin
         if (sum >= WRAP) begin
            x_offset <= COORD_W'(sum - WRAP);
         end else begin
            x_offset <= sum[COORD_W-1:0];
         end
      end
   end

   offset_in_range : assert property (@(posedge clk) disable iff (reset)
                                      x_offset < WRAP[COORD_W-1:0]);

endmodule

// File: rtl/vga_scan_driver.sv
// VGA raster source: pixel/line counters, sync and blanking decodes, line and
// frame strobes, a free-running frame counter and the per-frame scroll offset.
module vga_scan_driver #(
   parameter int H_DISPLAY   = vga_timing_pkg::H_DISPLAY,
   parameter int H_FRONT     = vga_timing_pkg::H_FRONT,
   parameter int H_SYNC      = vga_timing_pkg::H_SYNC,
   parameter int H_BACK      = vga_timing_pkg::H_BACK,
   parameter int V_DISPLAY   = vga_timing_pkg::V_DISPLAY,
   parameter int V_FRONT     = vga_timing_pkg::V_FRONT,
   parameter int V_SYNC      = vga_timing_pkg::V_SYNC,
   parameter int V_BACK      = vga_timing_pkg::V_BACK,
   parameter int SCROLL_WRAP = vga_timing_pkg::SCROLL_WRAP_DEFAULT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pause,
   input  logic [2:0] speed,
   output logic       hsync,
   output logic       vsync,
   output logic       display_on,
   output logic [9:0] pix_x,
   output logic [9:0] pix_y,
   output logic       line_tick,
   output logic       frame_tick,
   output logic [9:0] x_offset,
   output logic [7:0] frame_count
);
   localparam int H_TOTAL      = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL      = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
   localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
   localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
   localparam int V_SYNC_START = V_DISPLAY + V_FRONT;
   localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

   import vga_timing_pkg::*;

   localparam coord_t H_LAST    = coord_t'(H_TOTAL - 1);
   localparam coord_t V_LAST    = coord_t'(V_TOTAL - 1);
   localparam coord_t H_VIS     = coord_t'(H_DISPLAY);
   localparam coord_t V_VIS     = coord_t'(V_DISPLAY);
   localparam coord_t H_SYNC_LO = coord_t'(H_SYNC_START);
   localparam coord_t H_SYNC_HI = coord_t'(H_SYNC_END);
   localparam coord_t V_SYNC_LO = coord_t'(V_SYNC_START);
   localparam coord_t V_SYNC_HI = coord_t'(V_SYNC_END);

   coord_t               h_count;
   coord_t               v_count;
   logic [FRAME_W-1:0]   frames;
   scan_flags_t          flags;
   logic                 scroll_en;

   // Line counter advances on the same edge the pixel counter wraps.
   always_ff @(posedge clk) begin
      if (reset) begin
         h_count <= '0;
         v_count <= '0;
      end else if (h_count == H_LAST) begin
         h_count <= '0;
         v_count <= (v_count == V_LAST) ? '0 : v_count + 1'b1;
      end else begin
         h_count <= h_count + 1'b1;
      end
   end

   // NOTE: flags gets its full default before any branch, so no path through
   // this block leaves a bit unassigned and no latch is inferred.
   always_comb begin
      flags = FLAGS_IDLE;
      if (!reset) begin
         flags.hsync      = !in_window(h_count, H_SYNC_LO, H_SYNC_HI);
         flags.vsync      = !in_window(v_count, V_SYNC_LO, V_SYNC_HI);
         flags.display_on = (h_count < H_VIS) && (v_count < V_VIS);
         flags.line_tick  = (h_count == H_LAST);
         flags.frame_tick = (h_count == '0) && (v_count == V_VIS);
      end
   end

   // Frame count ignores pause; only the scroll offset freezes.
   always_ff @(posedge clk) begin
      if (reset) begin
         frames <= '0;
      end else if (flags.frame_tick) begin
         frames <= frames + 1'b1;
      end
   end

   assign scroll_en = flags.frame_tick && !pause;

   scroll_accumulator #(
      .SCROLL_WRAP (SCROLL_WRAP)
   ) u_scroll (
      .clk      (clk),
      .reset    (reset),
      .en       (scroll_en),
      .speed    (speed),
      .x_offset (x_offset)
   );

   assign hsync       = flags.hsync;
   assign vsync       = flags.vsync;
   assign display_on  = flags.display_on;
   assign line_tick   = flags.line_tick;
   assign frame_tick  = flags.frame_tick;
   assign pix_x       = h_count;
   assign pix_y       = v_count;
   assign frame_count = frames;

endmodule

// File: tb/tb_vga_scan_driver.sv
// Self-checking bench: a full-size 640x480 instance for line timing and a
// shrunken-raster instance for frame/scroll behaviour, both against a model.
module tb_vga_scan_driver;

   // Shrunken raster: 10 clocks per line, 7 lines per frame.
   localparam int S_HD = 6, S_HF = 1, S_HS = 2, S_HB = 1;
   localparam int S_VD = 4, S_VF = 1, S_VS = 1, S_VB = 1;
   localparam int S_HT = S_HD + S_HF + S_HS + S_HB;
   localparam int S_VT = S_VD + S_VF + S_VS + S_VB;
   localparam int S_FRAME = S_HT * S_VT;

   localparam int F_HD = 640, F_HF = 16, F_HS = 96, F_HB = 48;
   localparam int F_VD = 480, F_VF = 10, F_VS = 2, F_VB = 33;
   localparam int F_FRAME = 800 * 525;

   localparam int WRAP = 640;

   logic       clk = 1'b0;
   logic       reset;
   logic       pause;
   logic [2:0] speed;

   logic       hsync_f, vsync_f, display_on_f, line_tick_f, frame_tick_f;
   logic [9:0] pix_x_f, pix_y_f, x_offset_f;
   logic [7:0] frame_count_f;

   logic       hsync_s, vsync_s, display_on_s, line_tick_s, frame_tick_s;
   logic [9:0] pix_x_s, pix_y_s, x_offset_s;
   logic [7:0] frame_count_s;

   int n_checks = 0;
   int n_fail   = 0;

   // Model state: cycles since reset release, offset and frame count.
   int t_f = 0, off_f = 0, fc_f = 0;
   int t_s = 0, off_s = 0, fc_s = 0;

   int hs_low_f = 0, lt_cnt_f = 0, vs_low_s = 0, ft_cnt_s = 0;

   always #20 clk = ~clk;

   vga_scan_driver u_full (
      .clk (clk), .reset (reset), .pause (pause), .speed (speed),
      .hsync (hsync_f), .vsync (vsync_f), .display_on (display_on_f),
      .pix_x (pix_x_f), .pix_y (pix_y_f), .line_tick (line_tick_f),
      .frame_tick (frame_tick_f), .x_offset (x_offset_f), .frame_count (frame_count_f)
   );

   vga_scan_driver #(
      .H_DISPLAY (S_HD), .H_FRONT (S_HF), .H_SYNC (S_HS), .H_BACK (S_HB),
      .V_DISPLAY (S_VD), .V_FRONT (S_VF), .V_SYNC (S_VS), .V_BACK (S_VB),
      .SCROLL_WRAP (WRAP)
   ) u_small (
      .clk (clk), .reset (reset), .pause (pause), .speed (speed),
      .hsync (hsync_s), .vsync (vsync_s), .display_on (display_on_s),
      .pix_x (pix_x_s), .pix_y (pix_y_s), .line_tick (line_tick_s),
      .frame_tick (frame_tick_s), .x_offset (x_offset_s), .frame_count (frame_count_s)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Advance one model across a clock edge using the inputs sampled at that edge.
   task automatic advance(inout int t, inout int off, inout int fc,
                          input int frame_len, input int tick_pos);
      if (reset) begin
         t = 0; off = 0; fc = 0;
      end else begin
         if ((t % frame_len) == tick_pos) begin
            fc = (fc + 1) % 256;
            if (!pause) off = (off + int'(speed)) % WRAP;
         end
         t++;
      end
   endtask

   task automatic compare(input string p, input int t, input int off, input int fc,
                          input int hd, input int hf, input int hs, input int hb,
                          input int vd, input int vf, input int vs, input int vb,
                          input logic hs_o, input logic vs_o, input logic de_o,
                          input logic lt_o, input logic ft_o,
                          input logic [9:0] x_o, input logic [9:0] y_o,
                          input logic [9:0] off_o, input logic [7:0] fc_o);
      int ht, pos, x, y;
      ht  = hd + hf + hs + hb;
      pos = t % (ht * (vd + vf + vs + vb));
      x   = pos % ht;
      y   = pos / ht;
      check({p, "_pix_x"}, x_o, x);
      check({p, "_pix_y"}, y_o, y);
      check({p, "_hsync"}, hs_o, reset || !(x >= hd + hf && x < hd + hf + hs));
      check({p, "_vsync"}, vs_o, reset || !(y >= vd + vf && y < vd + vf + vs));
      check({p, "_display_on"}, de_o, !reset && x < hd && y < vd);
      check({p, "_line_tick"}, lt_o, !reset && x == ht - 1);
      check({p, "_frame_tick"}, ft_o, !reset && x == 0 && y == vd);
      check({p, "_x_offset"}, off_o, off);
      check({p, "_frame_count"}, fc_o, fc);
   endtask

   task automatic tick();
      @(posedge clk);
      advance(t_f, off_f, fc_f, F_FRAME, F_VD * 800);
      advance(t_s, off_s, fc_s, S_FRAME, S_VD * S_HT);
      @(negedge clk);
      compare("full", t_f, off_f, fc_f, F_HD, F_HF, F_HS, F_HB, F_VD, F_VF, F_VS, F_VB,
              hsync_f, vsync_f, display_on_f, line_tick_f, frame_tick_f,
              pix_x_f, pix_y_f, x_offset_f, frame_count_f);
      compare("small", t_s, off_s, fc_s, S_HD, S_HF, S_HS, S_HB, S_VD, S_VF, S_VS, S_VB,
              hsync_s, vsync_s, display_on_s, line_tick_s, frame_tick_s,
              pix_x_s, pix_y_s, x_offset_s, frame_count_s);
      if (hsync_f === 1'b0) hs_low_f++;
      if (line_tick_f === 1'b1) lt_cnt_f++;
      if (vsync_s === 1'b0) vs_low_s++;
      if (frame_tick_s === 1'b1) ft_cnt_s++;
   endtask

   // One small-raster frame; spd/pse are driven only in the frame_tick cycle,
   // every other cycle gets random values that must have no effect.
   task automatic run_frame(input logic [2:0] spd, input logic pse);
      vs_low_s = 0;
      ft_cnt_s = 0;
      for (int i = 0; i < S_FRAME; i++) begin
         if ((t_s % S_FRAME) == S_VD * S_HT) begin
            speed = spd;
            pause = pse;
         end else begin
            speed = 3'($urandom);
            pause = 1'($urandom);
         end
         tick();
      end
      check("frame_vsync_len", vs_low_s, S_VS * S_HT);
      check("frame_tick_count", ft_cnt_s, 1);
   endtask

   initial begin
      int fc_base;
      int seek;
      reset = 1'b1;
      pause = 1'b0;
      speed = 3'd0;

      repeat (3) tick();
      check("rst_pix_x", pix_x_f, 0);
      check("rst_hsync", hsync_f, 1);
      check("rst_display_on", display_on_f, 0);
      check("rst_x_offset", x_offset_s, 0);

      reset = 1'b0;
      pause = 1'b1;
      speed = 3'd5;
      tick();
      check("first_pix_x", pix_x_f, 1);
      check("first_display_on", display_on_f, 1);

      hs_low_f = 0;
      lt_cnt_f = 0;
      repeat (799) tick();
      check("line_hsync_len", hs_low_f, 96);
      check("line_tick_count", lt_cnt_f, 1);
      check("line_wrap_x", pix_x_f, 0);
      check("line_wrap_y", pix_y_f, 1);
      repeat (810) tick();
      check("paused_offset", x_offset_s, 0);

      repeat (90) run_frame(3'd7, 1'b0);
      run_frame(3'd5, 1'b0);
      check("offset_635", x_offset_s, 635);
      run_frame(3'd5, 1'b0);
      check("offset_wrap_0", x_offset_s, 0);

      fc_base = fc_s;
      repeat (3) run_frame(3'($urandom_range(1, 7)), 1'b1);
      check("pause_hold", x_offset_s, 0);
      repeat (2) run_frame(3'd0, 1'b0);
      check("speed0_hold", x_offset_s, 0);
      check("hold_frame_count", frame_count_s, (fc_base + 5) % 256);

      repeat (90) run_frame(3'd7, 1'b0);
      run_frame(3'd6, 1'b0);
      check("offset_636", x_offset_s, 636);
      run_frame(3'd7, 1'b0);
      check("offset_wrap_3", x_offset_s, 3);

      repeat (20) run_frame(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));

      seek = 0;
      while (((t_f % 800) < 656 || (t_f % 800) > 751) && seek < 1000) begin
         speed = 3'($urandom);
         pause = 1'($urandom);
         tick();
         seek++;
      end
      check("seek_hsync_in_budget", seek < 1000, 1);
      check("pre_reset_hsync", hsync_f, 0);
      reset = 1'b1;
      tick();
      check("mid_rst_hsync", hsync_f, 1);
      check("mid_rst_pix_x", pix_x_f, 0);
      check("mid_rst_pix_y", pix_y_f, 0);
      check("mid_rst_display_on", display_on_f, 0);
      check("mid_rst_x_offset", x_offset_s, 0);
      check("mid_rst_frame_count", frame_count_s, 0);
      reset = 1'b0;
      repeat (50) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
